// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array output drain.
// Provides the drain FSM state enum and the fixed-point format constants.
package sa_pkg;

    // Element format: 1 sign, 2 integer, 13 fractional bits.
    localparam int D_W    = 16;
    localparam int FRAC_W = 13;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } state_e;

endpackage

// File: rtl/sa_out_drain_if.sv
// Bus between the systolic-array wrapper, the drain and the row consumer.
// slave: drain side (takes matrix/shift/ready, drives row beats and status).
// master: environment side (drives matrix/shift/ready, observes row beats).
interface sa_out_drain_if #(
    parameter int D_W  = 16,
    parameter int SA_R = 16,
    parameter int SA_C = 16
);

    localparam int IDX_W = (SA_R > 1) ? $clog2(SA_R) : 1;

    logic                                 I_IN_VLD;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0]   I_IN_MAT;
    logic [3:0]                           I_SHIFT;
    logic                                 I_ROW_RDY;
    logic                                 O_ROW_VLD;
    logic [SA_C-1:0][D_W-1:0]             O_ROW_DATA;
    logic [IDX_W-1:0]                     O_ROW_IDX;
    logic                                 O_LAST;
    logic                                 O_BUSY;
    logic                                 O_DONE;
    logic                                 O_DROP;

    modport slave (
        input  I_IN_VLD,
        input  I_IN_MAT,
        input  I_SHIFT,
        input  I_ROW_RDY,
        output O_ROW_VLD,
        output O_ROW_DATA,
        output O_ROW_IDX,
        output O_LAST,
        output O_BUSY,
        output O_DONE,
        output O_DROP
    );

    modport master (
        output I_IN_VLD,
        output I_IN_MAT,
        output I_SHIFT,
        output I_ROW_RDY,
        input  O_ROW_VLD,
        input  O_ROW_DATA,
        input  O_ROW_IDX,
        input  O_LAST,
        input  O_BUSY,
        input  O_DONE,
        input  O_DROP
    );

endinterface

// File: rtl/sa_requant.sv
// Combinational requantiser for one element: round-half-up right shift
// with saturation. Ports: val_i (signed element), shift_i (0..15),
// val_o (requantised element). With SA_DRAIN_RELU_EN defined, negative
// results are clamped to zero.
module sa_requant
    import sa_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] val_i,
    input  logic [3:0]    shift_i,
    output logic [DW-1:0] val_o
);

    logic signed [DW:0] ext;
    logic signed [DW:0] rnd;
    logic signed [DW:0] sum;
    logic signed [DW:0] shr;
    logic [DW-1:0]      sat;
    logic [DW-1:0]      res;

    always_comb begin
        ext = {val_i[DW-1], val_i};
        // Rounding constant is only meaningful for shift_i != 0.
        rnd = {{DW{1'b0}}, 1'b1} << (shift_i - 4'd1);
        sum = ext + rnd;
        shr = sum >>> shift_i;

        // Top two bits disagree -> value does not fit DW bits.
        if (shr[DW] != shr[DW-1]) begin
            sat = shr[DW] ? {1'b1, {(DW-1){1'b0}}}
                          : {1'b0, {(DW-1){1'b1}}};
        end else begin
            sat = shr[DW-1:0];
        end

        res = (shift_i == 4'd0) ? val_i : sat;

`ifdef SA_DRAIN_RELU_EN
        if (res[DW-1]) begin
            res = '0;
        end
`endif

        val_o = res;
    end

endmodule

// File: rtl/sa_out_drain.sv
// Drains a systolic-array result matrix row by row over a valid/ready bus.
// Ports: I_CLK, I_ASYN_RST (async active-high), bus (sa_out_drain_if.slave).
// Captures a requantised copy on a rising edge of I_IN_VLD while idle,
// then streams rows 0..SA_R-1 with O_LAST on the final row and a one-cycle
// O_DONE afterwards. Optional macro SA_DRAIN_RELU_EN clamps negatives to 0.
module sa_out_drain #(
    parameter int D_W  = 16,
    parameter int SA_R = 16,
    parameter int SA_C = 16
) (
    input  logic          I_CLK,
    input  logic          I_ASYN_RST,
    sa_out_drain_if.slave bus
);

    import sa_pkg::*;

    localparam int IDX_W = (SA_R > 1) ? $clog2(SA_R) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SA_R - 1);

    typedef logic [SA_R-1:0][SA_C-1:0][D_W-1:0] mat_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             drop_q, drop_d;
    logic             vld_q;
    mat_t             buf_q;
    mat_t             rq;

    logic             cap_edge;
    logic             capture;
    logic             hs;

    for (genvar r = 0; r < SA_R; r++) begin : g_row
        for (genvar c = 0; c < SA_C; c++) begin : g_col
            sa_requant #(.DW(D_W)) u_rq (
                .val_i   (bus.I_IN_MAT[r][c]),
                .shift_i (bus.I_SHIFT),
                .val_o   (rq[r][c])
            );
        end
    end

    assign cap_edge = bus.I_IN_VLD & ~vld_q;
    assign hs       = (state_q == SEND) & bus.I_ROW_RDY;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        // Any capture edge seen away from IDLE is lost; remember it.
        drop_d  = drop_q | (cap_edge & (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (cap_edge) begin
                    capture = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
        if (I_ASYN_RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            drop_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
            vld_q   <= bus.I_IN_VLD;
        end
    end

    always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
        if (I_ASYN_RST) begin
            buf_q <= '0;
        end else if (capture) begin
            buf_q <= rq;
        end
    end

    assign bus.O_ROW_VLD  = (state_q == SEND);
    assign bus.O_ROW_DATA = (state_q == SEND) ? buf_q[idx_q] : '0;
    assign bus.O_ROW_IDX  = idx_q;
    assign bus.O_LAST     = (state_q == SEND) & (idx_q == LAST_IDX);
    assign bus.O_BUSY     = (state_q == LOAD) | (state_q == SEND);
    assign bus.O_DONE     = (state_q == DONE);
    assign bus.O_DROP     = drop_q;

endmodule

// File: doc/sa_out_drain.md
SA_OUT_DRAIN -- requirements
Module: sa_out_drain

Interface
REQ-001 SHALL have parameter D_W, default 16, element width (1 sign, 2 int, 13 frac bits).
REQ-002 SHALL have parameter SA_R, default 16, result rows.
REQ-003 SHALL have parameter SA_C, default 16, result columns.
REQ-004 SHALL have port I_CLK, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port I_ASYN_RST, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port I_IN_VLD, input, 1, level valid from the systolic array wrapper; stays high once the result is ready.
REQ-007 SHALL have port I_IN_MAT, input, D_W x [SA_R][SA_C], result matrix from the systolic array.
REQ-008 SHALL have port I_SHIFT, input, 4, right-shift requant amount, 0..15.
REQ-009 SHALL have port I_ROW_RDY, input, 1, downstream ready.
REQ-010 SHALL have port O_ROW_VLD, output, 1, row beat valid.
REQ-011 SHALL have port O_ROW_DATA, output, D_W x [SA_C], current row.
REQ-012 SHALL have port O_ROW_IDX, output, $clog2(SA_R), index of the current row.
REQ-013 SHALL have port O_LAST, output, 1, high with O_ROW_VLD on row SA_R-1.
REQ-014 SHALL have port O_BUSY, output, 1, high in states LOAD and SEND.
REQ-015 SHALL have port O_DONE, output, 1, one-cycle pulse after the last handshake.
REQ-016 SHALL have port O_DROP, output, 1, sticky flag for a capture edge ignored while busy.

Function
REQ-017 SHALL use FSM states IDLE, LOAD, SEND, DONE.
REQ-018 SHALL register I_IN_VLD each cycle and detect a capture edge as I_IN_VLD=1 while the registered copy is 0.
REQ-019 SHALL, in IDLE on a capture edge, write requant(I_IN_MAT[r][c], I_SHIFT) into buffer[r][c] for every element at that clock edge, and go to LOAD.
REQ-020 SHALL go from LOAD to SEND unconditionally, with O_ROW_IDX=0; O_ROW_VLD first asserts 2 cycles after the capture-edge cycle.
REQ-021 SHALL, in SEND, drive O_ROW_VLD=1 and O_ROW_DATA=buffer[O_ROW_IDX], and hold both stable until I_ROW_RDY=1.
REQ-022 SHALL, on a handshake (O_ROW_VLD & I_ROW_RDY) with O_ROW_IDX<SA_R-1, increment O_ROW_IDX at the next edge.
REQ-023 SHALL, on a handshake with O_ROW_IDX=SA_R-1, go to DONE.
REQ-024 SHALL, in DONE, assert O_DONE for exactly one cycle, return to IDLE, and clear O_ROW_IDX to 0.
REQ-025 SHALL define requant as follows:
- if shift=0, pass the value through;
- otherwise add 1<<(shift-1) in D_W+1 bits, then arithmetic right shift by shift;
- saturate to [-2^(D_W-1), 2^(D_W-1)-1].
REQ-026 SHALL, when a capture edge occurs outside IDLE, ignore it (buffer untouched) and set O_DROP until reset.
REQ-027 SHALL not re-capture while I_IN_VLD stays high after DONE; a new result requires I_IN_VLD to go low and then high again.
REQ-028 SHALL never reorder or skip rows, and SHALL allow back-to-back handshakes, one row per cycle.

Reset
REQ-029 SHALL, while I_ASYN_RST=1, force state to IDLE immediately, without waiting for a clock edge.
REQ-030 SHALL reset these outputs to 0: O_ROW_VLD, O_ROW_IDX, O_LAST, O_BUSY, O_DONE, O_DROP and O_ROW_DATA.
REQ-031 SHALL also reset the buffer and the registered I_IN_VLD to 0.
REQ-032 SHALL, when reset asserts mid-SEND, abort the frame with no O_DONE; after release, a new capture edge is required.

Configuration
REQ-033 SHALL, with SA_DRAIN_RELU_EN defined, clamp any negative requant result to 0 before writing the buffer.
REQ-034 SHALL, without SA_DRAIN_RELU_EN, pass signed requant results unchanged.

Structure
REQ-035 SHALL place the FSM state enum and the constants D_W=16 and FRAC_W=13 in shared package sa_pkg.
REQ-036 SHALL implement requant in one sub-module, sa_requant: combinational, one element, instantiated SA_R*SA_C times.
REQ-037 SHALL keep the FSM, the edge detect and the buffer in sa_out_drain; expected size is 150-300 lines of RTL.

Verification
REQ-038 SHALL cover full frame: I_SHIFT=0, I_IN_MAT[r][c]=r*16+c, I_ROW_RDY=1 -> rows 0..15 on consecutive cycles, O_LAST on row 15, O_DONE one cycle later.
REQ-039 SHALL cover rounding: inputs 0x0003 and 0xFFFD with I_SHIFT=1 -> 0x0002 and 0xFFFF.
REQ-040 SHALL cover saturation: input 0x7FFF with I_SHIFT=1 -> 0x4000; directly driven requant(0x7FFF + round) -> 0x7FFF, never wrapping.
REQ-041 SHALL cover backpressure: I_ROW_RDY low for 5 cycles on row 3 -> O_ROW_DATA/O_ROW_IDX stable, then row 4 follows the handshake.
REQ-042 SHALL cover drop: I_IN_VLD toggled 0->1 during SEND -> O_DROP=1, streamed data unchanged.
REQ-043 SHALL cover reset mid-frame: I_ASYN_RST pulsed at row 7 -> all outputs 0 at once, no O_DONE, and with SA_DRAIN_RELU_EN a -1 input is streamed as 0.
